key_dispatcher: RTL and testbench
=================================

KEY_DISPATCHER -- requirements
Module: key_dispatcher

Interface
REQ-001 Parameter DEPTH, default 8, event FIFO depth; power of two, minimum 4.
REQ-002 Parameter FREEZE_LVL, default 6, occupancy at or above which freeze is asserted.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 key_packet  in  11  key event; [10:8] type, [7:0] key data.
REQ-006 key_valid  in  1  one-cycle strobe qualifying key_packet.
REQ-007 mode  in  2  operating mode; 1 = Morse mode.
REQ-008 clear_ovf  in  1  clears the sticky overflow flag.
REQ-009 morse_pkt  out  11  packet presented to the Morse engine.
REQ-010 morse_valid  out  1  morse_pkt valid.
REQ-011 morse_ready  in  1  Morse engine accepts.
REQ-012 ctrl_pkt  out  11  packet presented to the UI/control engine.
REQ-013 ctrl_valid  out  1  ctrl_pkt valid.
REQ-014 ctrl_ready  in  1  control engine accepts.
REQ-015 freeze  out  1  back-pressure to KeyMapping.
REQ-016 overflow  out  1  sticky; an event was lost on a full FIFO.
REQ-017 drop  out  1  one-cycle pulse; an unroutable event was discarded.
REQ-018 fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 Input classification: types 0 (short) and 1 (long) are Morse-class, type 4 is control-class, and types 2, 3, 5, 6 and 7 are unroutable.
REQ-020 An unroutable event on key_valid shall not be queued, and drop shall pulse high in the following cycle.
REQ-021 The destination is fixed at push time and stored with the packet: Morse-class events go to Morse when mode==1 and to ctrl otherwise; control-class events always go to ctrl.
REQ-022 The FIFO holds 11-bit packets plus a 1-bit destination flag; push order is dispatch order, and head-of-line blocking is intended.
REQ-023 The FSM states are IDLE, PRESENT and FLUSH.
REQ-024 IDLE: the FIFO is empty and both valids are low; on push, go to PRESENT.
REQ-025 PRESENT: the head packet drives the port selected by its flag, and only that valid is high; the other port's pkt is 0.
REQ-026 PRESENT: on valid&&ready at the selected port, the head pops; go to IDLE if the FIFO becomes empty, otherwise stay in PRESENT.
REQ-027 A presented packet and its valid shall remain stable until accepted; the ready of the unselected port shall be ignored.
REQ-028 Latency: an event pushed into an empty FIFO at edge N is presented with valid high after edge N+1 (one registered stage).
REQ-029 A push on a full FIFO with no pop in the same cycle shall discard the event and set overflow.
REQ-030 A push on a full FIFO with a pop in the same cycle shall be accepted, leaving the count unchanged.
REQ-031 A simultaneous push and pop at any count shall leave the count unchanged and preserve order.
REQ-032 overflow shall stay set until clear_ovf; if clear_ovf and a new overflow occur in the same cycle, overflow stays set.
REQ-033 freeze shall be registered, high in the cycle after fifo_count >= FREEZE_LVL, and low in the cycle after fifo_count < FREEZE_LVL.
REQ-034 A change of mode, sampled against a registered copy, shall enter FLUSH for one cycle.
REQ-035 In FLUSH, the FIFO empties, both valids are low, and any key_valid in that cycle is discarded without setting drop; FLUSH then goes to IDLE.
REQ-036 Pointers wrap modulo DEPTH; fifo_count = DEPTH exactly when full.

Reset
REQ-037 While rst_n is low at a clock edge: FSM = IDLE, pointers = 0, fifo_count = 0, and all outputs are 0 (morse_pkt, ctrl_pkt, morse_valid, ctrl_valid, freeze, overflow, drop).
REQ-038 Reset mid-operation shall discard all queued and presented packets with no partial handshake afterwards; the registered mode copy loads the current mode, so no FLUSH follows reset.

Verification
REQ-039 Scenario: mode=1, push 0x001, morse_ready=1 -> morse_valid=1, morse_pkt=0x001 one cycle after the push; ctrl_valid stays 0.
REQ-040 Scenario: mode=1, push 0x420, then 0x101, ctrl_ready=0, morse_ready=1 -> ctrl holds 0x420 and 0x101 waits (head-of-line); after ctrl_ready=1, the Morse port presents 0x101 the next cycle.
REQ-041 Scenario: mode=0, push 0x101 -> the ctrl port presents 0x101; push 0x2AA -> drop pulses and fifo_count is unchanged.
REQ-042 Scenario: both readies 0, push 9 events -> freeze rises the cycle after count reaches 6, count saturates at 8, overflow=1 on the 9th; clear_ovf -> overflow=0.
REQ-043 Scenario: full FIFO, ready=1 with a simultaneous push -> count stays 8, overflow stays 0, and the new packet is output last in order.
REQ-044 Scenario: 3 events queued, mode changes 1->0 -> one FLUSH cycle, count=0, valids low, IDLE; then rst_n low mid-PRESENT -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/key_dispatcher_if.sv
// Purpose: key-event input stream plus Morse and control packet output streams.
// Latency: none, wiring only.
// Backpressure: each output valid waits on its own ready; the key input has no ready.
interface key_dispatcher_if;
  logic [10:0] key_packet;
  logic        key_valid;
  logic [10:0] morse_pkt;
  logic        morse_valid;
  logic        morse_ready;
  logic [10:0] ctrl_pkt;
  logic        ctrl_valid;
  logic        ctrl_ready;

  // Dispatcher side: consumes key events, sources both packet streams.
  modport master (
    input  key_packet, key_valid, morse_ready, ctrl_ready,
    output morse_pkt, morse_valid, ctrl_pkt, ctrl_valid
  );

  // Environment side: key source plus the Morse and control engines.
  modport slave (
    output key_packet, key_valid, morse_ready, ctrl_ready,
    input  morse_pkt, morse_valid, ctrl_pkt, ctrl_valid
  );
endinterface

// File: rtl/key_dispatcher.sv
// Purpose: classify key events, queue them with a fixed destination, present them in order.
// Latency: an event written at edge N is presented (valid high) after edge N+1.
// Backpressure: head-of-line blocking on the selected ready; freeze tracks occupancy, full drops set overflow.
module key_dispatcher #(
  parameter int DEPTH      = 8,
  parameter int FREEZE_LVL = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  key_dispatcher_if.master       kd,
  input  logic [1:0]             mode,
  input  logic                   clear_ovf,
  output logic                   freeze,
  output logic                   overflow,
  output logic                   drop,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic        to_morse;
    logic [10:0] pkt;
  } entry_t;

  typedef enum logic [1:0] {IDLE, PRESENT, FLUSH} state_t;

  state_t        state;
  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [1:0]    mode_q;

  logic [2:0] key_type;
  logic       is_morse;
  logic       is_ctrl;
  logic       unroutable;
  logic       mode_chg;
  logic       full;
  logic       pop;
  logic       push_req;
  logic       push;
  logic       ovf_evt;
  entry_t     push_ent;
  entry_t     head_ent;
  entry_t     next_ent;

  // Classify the incoming event and derive this cycle's push/pop/overflow decisions.
  always_comb begin
    key_type   = kd.key_packet[10:8];
    is_morse   = (key_type == 3'd0) || (key_type == 3'd1);
    is_ctrl    = (key_type == 3'd4);
    unroutable = kd.key_valid && !is_morse && !is_ctrl;
    mode_chg   = (mode != mode_q);
    full       = (fifo_count == CW'(DEPTH));
    // Only the selected port has its valid high, so the other ready drops out here.
    pop        = (state == PRESENT) &&
                 ((kd.morse_valid && kd.morse_ready) || (kd.ctrl_valid && kd.ctrl_ready));
    // A mode change flushes the queue, so anything arriving alongside it is discarded.
    push_req   = kd.key_valid && (is_morse || is_ctrl) && (state != FLUSH) && !mode_chg;
    push       = push_req && (!full || pop);
    ovf_evt    = push_req && full && !pop;
    push_ent.to_morse = is_morse && (mode == 2'd1);
    push_ent.pkt      = kd.key_packet;
    head_ent   = mem[rd_ptr];
    next_ent   = mem[rd_ptr + AW'(1)];
  end

  // Queue storage; the destination flag travels with the packet.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= push_ent;
    end
  end

  // Dispatch FSM with pointers, occupancy and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      fifo_count     <= '0;
      mode_q         <= mode;
      kd.morse_pkt   <= '0;
      kd.morse_valid <= 1'b0;
      kd.ctrl_pkt    <= '0;
      kd.ctrl_valid  <= 1'b0;
      freeze         <= 1'b0;
      overflow       <= 1'b0;
      drop           <= 1'b0;
    end else begin
      mode_q   <= mode;
      drop     <= unroutable && (state != FLUSH);
      freeze   <= (fifo_count >= CW'(FREEZE_LVL));
      overflow <= ovf_evt || (overflow && !clear_ovf);

      if (mode_chg) begin
        state          <= FLUSH;
        rd_ptr         <= '0;
        wr_ptr         <= '0;
        fifo_count     <= '0;
        kd.morse_pkt   <= '0;
        kd.morse_valid <= 1'b0;
        kd.ctrl_pkt    <= '0;
        kd.ctrl_valid  <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);

        case (state)
          IDLE: begin
            // Entries written in an earlier cycle reach the output register here.
            if (fifo_count != '0) begin
              kd.morse_pkt   <= head_ent.to_morse ? head_ent.pkt : 11'd0;
              kd.morse_valid <= head_ent.to_morse;
              kd.ctrl_pkt    <= head_ent.to_morse ? 11'd0 : head_ent.pkt;
              kd.ctrl_valid  <= !head_ent.to_morse;
              state          <= PRESENT;
            end
          end
          PRESENT: begin
            // Hold until accepted; on accept, move straight to the next stored entry.
            if (pop) begin
              if (fifo_count > CW'(1)) begin
                kd.morse_pkt   <= next_ent.to_morse ? next_ent.pkt : 11'd0;
                kd.morse_valid <= next_ent.to_morse;
                kd.ctrl_pkt    <= next_ent.to_morse ? 11'd0 : next_ent.pkt;
                kd.ctrl_valid  <= !next_ent.to_morse;
              end else begin
                kd.morse_pkt   <= '0;
                kd.morse_valid <= 1'b0;
                kd.ctrl_pkt    <= '0;
                kd.ctrl_valid  <= 1'b0;
                state          <= IDLE;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_key_dispatcher.sv
// Directed stimulus for key_dispatcher; expected packets are queued as issued and a
// negedge monitor pops and compares them on every accepted handshake.
// Status outputs (count, freeze, overflow, drop) are compared directly from the stimulus.
module tb_key_dispatcher;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       clear_ovf;
  logic       freeze;
  logic       overflow;
  logic       drop;
  logic [3:0] fifo_count;

  key_dispatcher_if kd();

  key_dispatcher #(.DEPTH(8), .FREEZE_LVL(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kd         (kd),
    .mode       (mode),
    .clear_ovf  (clear_ovf),
    .freeze     (freeze),
    .overflow   (overflow),
    .drop       (drop),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        to_morse;
    logic [10:0] pkt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic mon_take(input logic to_m, input logic [10:0] pkt, input logic [10:0] other);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_unexpected: got pkt 0x%0h on %s port, expected no packet",
               pkt, to_m ? "morse" : "ctrl");
    end else begin
      e = exp_q.pop_front();
      check("sb_port_is_morse", to_m, e.to_morse);
      check("sb_pkt", pkt, e.pkt);
      check("sb_unselected_pkt_zero", other, 0);
    end
  endtask

  // Scoreboard monitor: an accepted handshake is decided at the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (kd.morse_valid && kd.morse_ready) mon_take(1'b1, kd.morse_pkt, kd.ctrl_pkt);
      if (kd.ctrl_valid && kd.ctrl_ready)   mon_take(1'b0, kd.ctrl_pkt, kd.morse_pkt);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [10:0] p);
    kd.key_packet = p;
    kd.key_valid  = 1'b1;
    step(1);
    kd.key_valid  = 1'b0;
  endtask

  task automatic expect_pkt(input logic to_m, input logic [10:0] p);
    exp_t e;
    e.to_morse = to_m;
    e.pkt      = p;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_morse_valid"}, kd.morse_valid, 0);
    check({tag, "_ctrl_valid"},  kd.ctrl_valid,  0);
    check({tag, "_morse_pkt"},   kd.morse_pkt,   0);
    check({tag, "_ctrl_pkt"},    kd.ctrl_pkt,    0);
    check({tag, "_freeze"},      freeze,         0);
    check({tag, "_overflow"},    overflow,       0);
    check({tag, "_drop"},        drop,           0);
    check({tag, "_fifo_count"},  fifo_count,     0);
  endtask

  initial begin
    rst_n          = 1'b0;
    mode           = 2'd1;
    clear_ovf      = 1'b0;
    kd.key_packet  = '0;
    kd.key_valid   = 1'b0;
    kd.morse_ready = 1'b0;
    kd.ctrl_ready  = 1'b0;
    step(2);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Morse-class event in Morse mode goes to the Morse port one cycle after the push.
    kd.morse_ready = 1'b1;
    expect_pkt(1'b1, 11'h001);
    push(11'h001);
    check("s1_count_after_push", fifo_count, 1);
    check("s1_not_yet_valid", kd.morse_valid, 0);
    step(1);
    check("s1_morse_valid", kd.morse_valid, 1);
    check("s1_morse_pkt", kd.morse_pkt, 11'h001);
    check("s1_ctrl_valid", kd.ctrl_valid, 0);
    step(1);
    check("s1_count_after_pop", fifo_count, 0);
    check("s1_morse_valid_low", kd.morse_valid, 0);

    // Head-of-line: control packet blocks the Morse packet behind it.
    kd.ctrl_ready = 1'b0;
    expect_pkt(1'b0, 11'h420);
    expect_pkt(1'b1, 11'h101);
    push(11'h420);
    push(11'h101);
    step(2);
    check("s2_ctrl_hold_valid", kd.ctrl_valid, 1);
    check("s2_ctrl_hold_pkt", kd.ctrl_pkt, 11'h420);
    check("s2_morse_blocked", kd.morse_valid, 0);
    check("s2_count", fifo_count, 2);
    kd.ctrl_ready = 1'b1;
    step(1);
    kd.ctrl_ready = 1'b0;
    check("s2_morse_next_valid", kd.morse_valid, 1);
    check("s2_morse_next_pkt", kd.morse_pkt, 11'h101);
    check("s2_ctrl_low", kd.ctrl_valid, 0);
    step(1);
    check("s2_count_empty", fifo_count, 0);

    // Mode 0: Morse-class goes to ctrl; unroutable event pulses drop only.
    kd.morse_ready = 1'b0;
    mode = 2'd0;
    step(2);
    expect_pkt(1'b0, 11'h101);
    push(11'h101);
    check("s3_count", fifo_count, 1);
    step(1);
    check("s3_ctrl_valid", kd.ctrl_valid, 1);
    check("s3_ctrl_pkt", kd.ctrl_pkt, 11'h101);
    check("s3_morse_valid", kd.morse_valid, 0);
    push(11'h2AA);
    check("s3_drop_pulse", drop, 1);
    check("s3_count_unchanged", fifo_count, 1);
    step(1);
    check("s3_drop_one_cycle", drop, 0);
    kd.ctrl_ready = 1'b1;
    step(1);
    kd.ctrl_ready = 1'b0;
    check("s3_count_after_pop", fifo_count, 0);

    // Fill with no readies: freeze lags count by a cycle, 9th push overflows.
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) expect_pkt(1'b0, 11'h400 + 11'(i - 1));
      kd.key_packet = 11'h400 + 11'(i - 1);
      kd.key_valid  = 1'b1;
      step(1);
      check($sformatf("s4_count_%0d", i), fifo_count, (i > 8) ? 8 : i);
      check($sformatf("s4_freeze_%0d", i), freeze, (i >= 7) ? 1 : 0);
      check($sformatf("s4_overflow_%0d", i), overflow, (i == 9) ? 1 : 0);
    end
    kd.key_valid = 1'b0;
    step(1);
    check("s4_overflow_sticky", overflow, 1);
    clear_ovf = 1'b1;
    step(1);
    clear_ovf = 1'b0;
    check("s4_overflow_cleared", overflow, 0);

    // Full queue with simultaneous pop and push: count holds, new packet comes out last.
    kd.ctrl_ready = 1'b1;
    expect_pkt(1'b0, 11'h4AB);
    push(11'h4AB);
    check("s5_count_full", fifo_count, 8);
    check("s5_no_overflow", overflow, 0);
    drain("s5_drain_in_order", 20);
    check("s5_count_empty", fifo_count, 0);
    kd.ctrl_ready = 1'b0;

    // Mode change flushes queued events; key events during FLUSH vanish silently.
    mode = 2'd1;
    step(2);
    push(11'h001);
    push(11'h002);
    push(11'h420);
    check("s6_count_3", fifo_count, 3);
    check("s6_morse_valid", kd.morse_valid, 1);
    check("s6_morse_pkt", kd.morse_pkt, 11'h001);
    mode = 2'd0;
    step(1);
    check("s6_flush_count", fifo_count, 0);
    check("s6_flush_morse_valid", kd.morse_valid, 0);
    check("s6_flush_ctrl_valid", kd.ctrl_valid, 0);
    push(11'h2AA);
    check("s6_flush_no_drop", drop, 0);
    check("s6_flush_no_queue", fifo_count, 0);

    // Reset in the middle of a presented packet.
    push(11'h420);
    step(1);
    check("s7_ctrl_presented", kd.ctrl_valid, 1);
    check("s7_ctrl_pkt", kd.ctrl_pkt, 11'h420);
    rst_n = 1'b0;
    mode  = 2'd1;
    step(1);
    check_all_zero("s7_reset");
    step(1);
    rst_n = 1'b1;
    kd.morse_ready = 1'b1;
    kd.ctrl_ready  = 1'b1;
    expect_pkt(1'b1, 11'h001);
    push(11'h001);
    drain("s7_post_reset_no_flush", 10);
    check("s7_ctrl_stays_low", kd.ctrl_valid, 0);
    check("s7_count_empty", fifo_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
